decade_chain_ctrl: RTL and testbench
====================================

Name: decade_chain_ctrl

Overview:
- Sequencer and controller for a chain of cascaded decade (mod-10) counter digits.
- Accepts start/pause/resume/abort commands over a valid/ready handshake and latches a BCD terminal count.
- Advances the BCD chain on qualified tick pulses and signals completion.
- Sits between the control logic and the decade-counter datapath, giving it a synchronous, single-clock timer/stopwatch front end.

Parameters:
- DIGITS, 4, number of cascaded BCD digits; legal range 1..8.
- CMD_W, 2, width of the command opcode field; fixed at 2, not to be overridden.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- clr  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_op  input  CMD_W  command opcode: 00 START, 01 PAUSE, 10 RESUME, 11 ABORT.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
- limit  input  4*DIGITS  BCD terminal count; sampled only on START acceptance.
- tick  input  1  count-enable pulse; one increment per cycle high.
- count  output  4*DIGITS  current BCD count; digit 0 in bits [3:0].
- state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE.
- busy  output  1  high in RUN or PAUSE.
- done  output  1  one-cycle pulse on reaching limit.
- err  output  1  sticky error flag; cleared by the next accepted legal START.

Behaviour:
- Reset values, applied at the first rising clk edge with clr=1: state=IDLE, count=0, done=0, err=0, cmd_ready=0, limit register=0. Reset overrides any command or tick in the same cycle and is legal mid-operation.
- cmd_ready is 1 in every cycle after reset, except the cycle in which done is high, when it is 0.
- Command handling has priority over tick: in any cycle where a command is accepted, tick is ignored.
- START, accepted in IDLE or DONE:
  - If any nibble of limit is >9: err=1, state stays unchanged, count unchanged.
  - Otherwise: latch limit, count=0, err=0.
  - If latched limit==0: go to DONE, with done=1 on the following cycle.
  - Else go to RUN.
- PAUSE, accepted in RUN: go to PAUSE; count frozen; ticks ignored.
- RESUME, accepted in PAUSE: go to RUN; counting resumes on the next tick.
- ABORT, accepted in any state: go to IDLE, count=0, done=0. Not an error.
- Illegal commands (START in RUN/PAUSE, PAUSE outside RUN, RESUME outside PAUSE): consumed, no state change, err=1.
- RUN with tick=1 and no command:
  - Digit 0 increments.
  - A digit at 9 wraps to 0 and carries into the next digit in the same cycle (full ripple within one clock; no multi-cycle carry).
  - The most significant digit wrapping from 9 cannot occur, because limit is at most all-9s.
- Terminal condition: when the incremented count equals the latched limit, the same edge sets state=DONE and count=limit. done=1 for exactly one cycle, the cycle after DONE is entered.
- DONE: count holds; ticks ignored; exits only on START, ABORT or clr.
- Latency:
  - Command to state change: 1 cycle.
  - Tick to count update: 1 cycle.
  - Final tick to done pulse: 2 cycles.
- busy = (state==RUN) || (state==PAUSE), decoded combinationally from the state register.
- All outputs are registered except busy.

Optional Feature:
- Macro: DECADE_CHAIN_AUTO_RELOAD_EN.
- Defined: on reaching limit in RUN, count returns to 0 on the next tick boundary (the matching edge writes 0, not limit), state stays RUN, and done pulses once per period on the cycle after the match. The periodic done pulse does not drop cmd_ready. PAUSE, RESUME and ABORT behave as above.
- Undefined: the block stops in DONE as specified in Behaviour.

Test Plan (DIGITS=2):
- clr=1 for 2 cycles with tick=1 and cmd_valid=1 -> count=00, state=IDLE, done=0, err=0, cmd_ready=0 during reset, then 1.
- START with limit=0x12, then 12 ticks -> count steps 01..09,10,11,12. Digit-0 wrap at 09->10 occurs with the carry in the same cycle. state=DONE after tick 12; done=1 exactly one cycle later; cmd_ready=0 in that cycle; further ticks leave count=0x12.
- START limit=0x25, 7 ticks, PAUSE, 5 ticks, RESUME, 3 ticks -> count=0x07 after the first run phase, still 0x07 after the paused ticks, 0x10 at the end; busy=1 throughout.
- START with limit=0x1A -> err=1, state=IDLE, count=00. Then START with limit=0x03 -> err=0, state=RUN.
- In RUN at count=0x04 with limit=0x09: PAUSE asserted in the same cycle as tick=1 -> count stays 0x04, state=PAUSE. RESUME while in RUN -> err=1, no state change. ABORT -> IDLE, count=00.
- With DECADE_CHAIN_AUTO_RELOAD_EN defined, limit=0x03 and 9 ticks -> count sequence 1,2,0,1,2,0,1,2,0; done pulses 3 times; state remains RUN.

Source files
------------

// File: rtl/decade_chain_ctrl.sv
// Command-driven sequencer for a chain of cascaded BCD (mod-10) digits with a latched terminal count.
// Optional build macro DECADE_CHAIN_AUTO_RELOAD_EN: restart from zero at the limit instead of stopping in DONE.
module decade_chain_ctrl #(
  parameter int DIGITS = 4,
  parameter int CMD_W  = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  cmd_valid,
  input  logic [CMD_W-1:0]      cmd_op,
  output logic                  cmd_ready,
  input  logic [4*DIGITS-1:0]   limit,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   count,
  output logic [1:0]            state,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int W = 4 * DIGITS;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic [CMD_W-1:0] OP_START  = CMD_W'(0);
  localparam logic [CMD_W-1:0] OP_PAUSE  = CMD_W'(1);
  localparam logic [CMD_W-1:0] OP_RESUME = CMD_W'(2);

  // Every nibble must be a decimal digit for a limit to be accepted.
  function automatic logic bcd_ok(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  // Full-ripple BCD increment: every carry settles within the same clock.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [W-1:0] term_count;
  logic         done_pend;
  logic         pend_quiet;

  logic [1:0]   state_nxt;
  logic [W-1:0] count_nxt;
  logic [W-1:0] term_nxt;
  logic         err_nxt;
  logic         pend_nxt;
  logic         quiet_nxt;
  logic         done_nxt;
  logic         ready_nxt;

  logic         cmd_acc;
  logic [W-1:0] count_inc;

  assign cmd_acc   = cmd_valid && cmd_ready;
  assign count_inc = bcd_inc(count);
  assign busy      = (state == ST_RUN) || (state == ST_PAUSE);

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    term_nxt  = term_count;
    err_nxt   = err;
    pend_nxt  = 1'b0;
    quiet_nxt = 1'b0;
    done_nxt  = done_pend;

    if (cmd_acc) begin
      case (cmd_op)
        OP_START: begin
          if ((state == ST_IDLE) || (state == ST_DONE)) begin
            if (!bcd_ok(limit)) begin
              err_nxt = 1'b1;
            end else begin
              term_nxt  = limit;
              count_nxt = '0;
              err_nxt   = 1'b0;
              if (limit == '0) begin
                state_nxt = ST_DONE;
                pend_nxt  = 1'b1;
              end else begin
                state_nxt = ST_RUN;
              end
            end
          end else begin
            err_nxt = 1'b1;
          end
        end
        OP_PAUSE: begin
          if (state == ST_RUN) state_nxt = ST_PAUSE;
          else                 err_nxt   = 1'b1;
        end
        OP_RESUME: begin
          if (state == ST_PAUSE) state_nxt = ST_RUN;
          else                   err_nxt   = 1'b1;
        end
        default: begin
          // ABORT is legal from any state and cancels a pending done pulse.
          state_nxt = ST_IDLE;
          count_nxt = '0;
          done_nxt  = 1'b0;
        end
      endcase
    end else if ((state == ST_RUN) && tick) begin
      if (count_inc == term_count) begin
`ifdef DECADE_CHAIN_AUTO_RELOAD_EN
        count_nxt = '0;
        pend_nxt  = 1'b1;
        quiet_nxt = 1'b1;
`else
        count_nxt = count_inc;
        state_nxt = ST_DONE;
        pend_nxt  = 1'b1;
`endif
      end else begin
        count_nxt = count_inc;
      end
    end

    // The handshake stalls only for a terminal done pulse, never a periodic one.
    ready_nxt = !(done_nxt && !pend_quiet);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_IDLE;
      count      <= '0;
      term_count <= '0;
      err        <= 1'b0;
      done       <= 1'b0;
      done_pend  <= 1'b0;
      pend_quiet <= 1'b0;
      cmd_ready  <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      term_count <= term_nxt;
      err        <= err_nxt;
      done       <= done_nxt;
      done_pend  <= pend_nxt;
      pend_quiet <= quiet_nxt;
      cmd_ready  <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_decade_chain_ctrl.sv
// Directed self-checking bench for decade_chain_ctrl with DIGITS=2.
module tb_decade_chain_ctrl;

  localparam int DIGITS = 2;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         clr;
  logic         cmd_valid;
  logic [1:0]   cmd_op;
  logic         cmd_ready;
  logic [W-1:0] limit;
  logic         tick;
  logic [W-1:0] count;
  logic [1:0]   state;
  logic         busy;
  logic         done;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11;
  localparam logic [1:0] START = 2'b00, PAUSE_OP = 2'b01, RESUME = 2'b10, ABORT = 2'b11;

  decade_chain_ctrl #(.DIGITS(DIGITS), .CMD_W(2)) dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_op    (cmd_op),
    .cmd_ready (cmd_ready),
    .limit     (limit),
    .tick      (tick),
    .count     (count),
    .state     (state),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one command for exactly one edge.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] lim);
    cmd_valid = 1'b1;
    cmd_op    = op;
    limit     = lim;
    cycle();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] seq12 [12];
    seq12 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
              8'h07, 8'h08, 8'h09, 8'h10, 8'h11, 8'h12};

    // Reset with tick and a command present: both must be ignored.
    clr = 1'b1; tick = 1'b1; cmd_valid = 1'b1; cmd_op = START; limit = 8'h05;
    cycle();
    check("rst_count", count, 8'h00);
    check("rst_state", state, IDLE);
    check("rst_done",  done, 1'b0);
    check("rst_err",   err, 1'b0);
    check("rst_ready", cmd_ready, 1'b0);
    cycle();
    check("rst_ready2", cmd_ready, 1'b0);
    check("rst_count2", count, 8'h00);
    clr = 1'b0; tick = 1'b0; cmd_valid = 1'b0;
    cycle();
    check("post_rst_ready", cmd_ready, 1'b1);
    check("post_rst_state", state, IDLE);

`ifndef DECADE_CHAIN_AUTO_RELOAD_EN
    // Count to 12, including the 09->10 carry, then stop in DONE.
    issue(START, 8'h12);
    check("s12_state", state, RUN);
    check("s12_count0", count, 8'h00);
    tick = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      check($sformatf("s12_count_t%0d", i + 1), count, seq12[i]);
      if (i < 11) check($sformatf("s12_busy_t%0d", i + 1), busy, 1'b1);
    end
    check("s12_state_done", state, DONE);
    check("s12_done_early", done, 1'b0);
    check("s12_ready_pre", cmd_ready, 1'b1);
    cycle();
    check("s12_done_pulse", done, 1'b1);
    check("s12_ready_drop", cmd_ready, 1'b0);
    check("s12_count_hold", count, 8'h12);
    cycle();
    check("s12_done_end", done, 1'b0);
    check("s12_ready_back", cmd_ready, 1'b1);
    check("s12_count_hold2", count, 8'h12);
    check("s12_busy_done", busy, 1'b0);
    tick = 1'b0;
`endif

    // Run, pause with ticks present, resume.
    issue(ABORT, 8'h00);
    issue(START, 8'h25);
    check("p_state_run", state, RUN);
    tick = 1'b1;
    repeat (7) cycle();
    check("p_count7", count, 8'h07);
    tick = 1'b0;
    issue(PAUSE_OP, 8'h00);
    check("p_state_pause", state, PAUSE);
    tick = 1'b1;
    repeat (5) cycle();
    check("p_count_frozen", count, 8'h07);
    check("p_busy_pause", busy, 1'b1);
    tick = 1'b0;
    issue(RESUME, 8'h00);
    check("p_state_resume", state, RUN);
    tick = 1'b1;
    repeat (3) cycle();
    tick = 1'b0;
    check("p_count_end", count, 8'h10);
    check("p_busy_end", busy, 1'b1);

    // Non-BCD limit is rejected; a legal START then clears err.
    issue(ABORT, 8'h00);
    check("a_state_idle", state, IDLE);
    check("a_count_zero", count, 8'h00);
    issue(START, 8'h1A);
    check("bad_err", err, 1'b1);
    check("bad_state", state, IDLE);
    check("bad_count", count, 8'h00);
    issue(START, 8'h03);
    check("good_err", err, 1'b0);
    check("good_state", state, RUN);

    // Command wins over a same-cycle tick; illegal RESUME in RUN.
    issue(ABORT, 8'h00);
    issue(START, 8'h09);
    tick = 1'b1;
    repeat (4) cycle();
    check("c_count4", count, 8'h04);
    issue(PAUSE_OP, 8'h00);
    check("c_count_pause", count, 8'h04);
    check("c_state_pause", state, PAUSE);
    tick = 1'b0;
    issue(RESUME, 8'h00);
    check("c_state_run", state, RUN);
    check("c_err_clean", err, 1'b0);
    issue(RESUME, 8'h00);
    check("c_illegal_err", err, 1'b1);
    check("c_illegal_state", state, RUN);
    check("c_illegal_count", count, 8'h04);
    issue(ABORT, 8'h00);
    check("c_abort_state", state, IDLE);
    check("c_abort_count", count, 8'h00);
    check("c_err_sticky", err, 1'b1);
    issue(PAUSE_OP, 8'h00);
    check("c_pause_idle_state", state, IDLE);

`ifndef DECADE_CHAIN_AUTO_RELOAD_EN
    // Zero limit completes immediately.
    issue(START, 8'h00);
    check("z_state", state, DONE);
    check("z_err", err, 1'b0);
    check("z_done_early", done, 1'b0);
    cycle();
    check("z_done_pulse", done, 1'b1);
    check("z_ready_drop", cmd_ready, 1'b0);
    cycle();
    check("z_done_end", done, 1'b0);
    check("z_ready_back", cmd_ready, 1'b1);
`else
    // Periodic mode: 0x03 repeats 1,2,0 and pulses done the cycle after each match.
    issue(ABORT, 8'h00);
    issue(START, 8'h03);
    begin
      int pulses;
      logic [W-1:0] exp_cnt;
      pulses = 0;
      for (int k = 1; k <= 10; k++) begin
        tick = (k <= 9);
        cycle();
        exp_cnt = (k <= 9) ? W'(k % 3) : 8'h00;
        check($sformatf("ar_count_%0d", k), count, exp_cnt);
        check($sformatf("ar_done_%0d", k), done, (k > 1) && ((k - 1) % 3 == 0));
        check($sformatf("ar_ready_%0d", k), cmd_ready, 1'b1);
        check($sformatf("ar_state_%0d", k), state, RUN);
        if (done) pulses++;
      end
      check("ar_pulses", pulses, 3);
    end
    tick = 1'b0;
`endif

    // Reset mid-run overrides the tick.
    issue(ABORT, 8'h00);
    issue(START, 8'h50);
    tick = 1'b1;
    repeat (2) cycle();
    check("m_count2", count, 8'h02);
    clr = 1'b1;
    cycle();
    clr = 1'b0; tick = 1'b0;
    check("m_state", state, IDLE);
    check("m_count", count, 8'h00);
    check("m_ready", cmd_ready, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
